// File: rtl/nes_rom_pkg.sv
// ============================================================================
// Module      : nes_rom_pkg
// Description : iNES loader constants, FSM state and error-code types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nes_rom_pkg;

    localparam logic [31:0] INES_MAGIC     = 32'h4E45_531A;
    localparam int          INES_HDR_LEN   = 16;
    localparam int          PRG_BANK_BYTES = 16384;
    localparam int          CHR_BANK_BYTES = 8192;
    localparam int          TRAINER_BYTES  = 512;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_TRN  = 3'd2,
        S_PRG  = 3'd3,
        S_CHR  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } ldr_state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_MAGIC  = 2'd1,
        ERR_FORMAT = 2'd2,
        ERR_RSVD   = 2'd3
    } ldr_err_t;

    // Expected header byte at offsets 0..3.
    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return INES_MAGIC[31:24];
            2'd1:    return INES_MAGIC[23:16];
            2'd2:    return INES_MAGIC[15:8];
            default: return INES_MAGIC[7:0];
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ines_hdr_check.sv
// ============================================================================
// Module      : ines_hdr_check
// Description : Combinational magic / format check for iNES header bytes 0..7.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ines_hdr_check
    import nes_rom_pkg::*;
#(
    parameter int MAX_PRG_BANKS = 1
) (
    input  logic [3:0] idx,
    input  logic [7:0] data,
    input  logic [7:0] prg_banks,
    input  logic [7:0] chr_banks,
    input  logic [3:0] mapper_lo,
    output logic       magic_ok,
    output logic       format_ok
);

    always_comb begin
        magic_ok  = 1'b1;
        format_ok = 1'b1;
        if (idx < 4'd4 && data != magic_byte(idx[1:0])) begin
            magic_ok = 1'b0;
        end
        // At byte 7 the bank counts and mapper low nibble are already latched.
        if (idx == 4'd7) begin
            format_ok = (prg_banks >= 8'd1) && (int'(prg_banks) <= MAX_PRG_BANKS) &&
                        (chr_banks == 8'd1) && (data[7:4] == 4'd0) && (mapper_lo == 4'd0);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ines_loader.sv
// ============================================================================
// Module      : ines_loader
// Description : Streams an NROM iNES image into the cartridge ROM store.
//               Optional trainer skipping via INES_TRAINER_SKIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ines_loader
    import nes_rom_pkg::*;
#(
    parameter int ADDR_W        = 15,
    parameter int MAX_PRG_BANKS = 1
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        prg_banks,
    output logic [7:0]        chr_banks,
    output logic              mirror_v
);

    localparam int CW = ADDR_W + 1;

    ldr_state_t        r_state, w_state_nxt;
    ldr_err_t          r_err_code, w_err_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [ADDR_W:0]   w_prg_end;
    logic [ADDR_W:0]   w_chr_end;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_prg_banks;
    logic [7:0]        r_chr_banks;
    logic              r_mirror_v;
    logic [3:0]        r_map_lo;
    logic              r_trainer;
    logic              w_acc;
    logic              w_restart;
    logic              w_magic_ok;
    logic              w_chk_fmt_ok;
    logic              w_fmt_ok;
`ifdef INES_TRAINER_SKIP_EN
    logic [8:0]        r_trn_cnt;
`endif

    assign in_ready  = (r_state == S_HDR) || (r_state == S_TRN) ||
                       (r_state == S_PRG) || (r_state == S_CHR);
    assign busy      = in_ready;
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERR);
    assign err_code  = r_err_code;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign prg_banks = r_prg_banks;
    assign chr_banks = r_chr_banks;
    assign mirror_v  = r_mirror_v;

    assign w_acc     = in_valid && in_ready;
    assign w_restart = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_cnt_nxt = r_cnt + 1'b1;
    // Exclusive end offsets of the PRG and CHR regions in the stored image.
    assign w_prg_end = CW'(INES_HDR_LEN + int'(r_prg_banks) * PRG_BANK_BYTES);
    assign w_chr_end = CW'(INES_HDR_LEN + int'(r_prg_banks) * PRG_BANK_BYTES + CHR_BANK_BYTES);

    ines_hdr_check #(
        .MAX_PRG_BANKS (MAX_PRG_BANKS)
    ) u_hdr_check (
        .idx       (r_cnt[3:0]),
        .data      (in_data),
        .prg_banks (r_prg_banks),
        .chr_banks (r_chr_banks),
        .mapper_lo (r_map_lo),
        .magic_ok  (w_magic_ok),
        .format_ok (w_chk_fmt_ok)
    );

`ifdef INES_TRAINER_SKIP_EN
    assign w_fmt_ok = w_chk_fmt_ok;
`else
    assign w_fmt_ok = w_chk_fmt_ok && !(r_cnt[3:0] == 4'd7 && r_trainer);
`endif

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_err_code <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err_code;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_HDR;
            S_HDR: begin
                if (w_acc) begin
                    if (!w_magic_ok) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = ERR_MAGIC;
                    end else if (!w_fmt_ok) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = ERR_FORMAT;
                    end else if (r_cnt[3:0] == 4'd15) begin
`ifdef INES_TRAINER_SKIP_EN
                        w_state_nxt = r_trainer ? S_TRN : S_PRG;
`else
                        w_state_nxt = S_PRG;
`endif
                    end
                end
            end
`ifdef INES_TRAINER_SKIP_EN
            S_TRN: if (w_acc && r_trn_cnt == 9'(TRAINER_BYTES - 1)) w_state_nxt = S_PRG;
`endif
            S_PRG: if (w_acc && w_cnt_nxt == w_prg_end) w_state_nxt = S_CHR;
            S_CHR: if (w_acc && w_cnt_nxt == w_chr_end) w_state_nxt = S_DONE;
            S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_HDR;
                    w_err_nxt   = ERR_NONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'd0;
            r_prg_banks <= 8'd0;
            r_chr_banks <= 8'd0;
            r_mirror_v  <= 1'b0;
            r_map_lo    <= 4'd0;
            r_trainer   <= 1'b0;
        end else begin
            // Trainer bytes are consumed without advancing the store address.
            r_wr_en <= w_acc && (r_state != S_TRN);
            if (w_restart) begin
                r_cnt <= '0;
            end else if (w_acc && r_state != S_TRN) begin
                r_cnt <= w_cnt_nxt;
            end
            if (w_acc) begin
                r_wr_addr <= r_cnt[ADDR_W-1:0];
                r_wr_data <= in_data;
            end
            if (w_acc && r_state == S_HDR) begin
                if (r_cnt[3:0] == 4'd4) r_prg_banks <= in_data;
                if (r_cnt[3:0] == 4'd5) r_chr_banks <= in_data;
                if (r_cnt[3:0] == 4'd6) begin
                    r_mirror_v <= in_data[0];
                    r_trainer  <= in_data[2];
                    r_map_lo   <= in_data[7:4];
                end
            end
        end
    end

`ifdef INES_TRAINER_SKIP_EN
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            r_trn_cnt <= 9'd0;
        end else if (r_state != S_TRN) begin
            r_trn_cnt <= 9'd0;
        end else if (w_acc) begin
            r_trn_cnt <= r_trn_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ines_loader.sv
// ============================================================================
// Module      : tb_ines_loader
// Description : Self-checking bench for ines_loader (header vectors + full loads).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ines_loader;

    localparam int ADDR_W  = 15;
    localparam int IMG_LEN = 24592;

    logic              cpu_clk = 1'b0;
    logic              rst     = 1'b0;
    logic              start   = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [7:0]        prg_banks;
    logic [7:0]        chr_banks;
    logic              mirror_v;

    always #5 cpu_clk = ~cpu_clk;

    ines_loader #(
        .ADDR_W        (ADDR_W),
        .MAX_PRG_BANKS (1)
    ) dut (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .prg_banks (prg_banks),
        .chr_banks (chr_banks),
        .mirror_v  (mirror_v)
    );

    int         tests = 0;
    int         fails = 0;
    int         wr_cnt = 0;
    int         wr_bad = 0;
    int         exp_last = -1;
    int         cur_addr = 0;
    bit         cur_trn = 1'b0;
    bit         pend = 1'b0;
    int         pend_addr = 0;
    logic [7:0] pend_data = 8'd0;
    int         last_addr = 0;
    logic [7:0] last_data = 8'd0;

    typedef struct {
        string       name;
        logic [63:0] hdr;
        int          code;
        int          last;
    } vec_t;

    vec_t vecs[11];

    // Write monitor: every accepted non-trainer byte must appear exactly one cycle later.
    always @(negedge cpu_clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (wr_en) begin
                wr_cnt++;
                last_addr = int'(wr_addr);
                last_data = wr_data;
            end
            if (pend) begin
                if (!wr_en || int'(wr_addr) != pend_addr || wr_data != pend_data ||
                    done != (pend_addr == exp_last)) begin
                    wr_bad++;
                    if (wr_bad < 6)
                        $display("FAIL write: got en=%0b addr=%0h data=%0h done=%0b, need addr=%0h data=%0h done=%0b",
                                 wr_en, wr_addr, wr_data, done, pend_addr, pend_data, pend_addr == exp_last);
                end
            end else if (wr_en) begin
                wr_bad++;
                if (wr_bad < 6)
                    $display("FAIL write: unexpected strobe addr=%0h data=%0h", wr_addr, wr_data);
            end
            pend      = in_valid && in_ready && !cur_trn;
            pend_addr = cur_addr;
            pend_data = in_data;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] img_byte(input int off);
        logic [127:0] hdr;
        hdr = 128'h4E45531A_01010000_00000000_00000000;
        if (off < 16) return hdr[127 - 8*off -: 8];
        return 8'(off ^ (off >> 8));
    endfunction

    // Called at posedge+1; returns at posedge+1 after the byte was accepted.
    task automatic send(input logic [7:0] d, input int addr, input bit trn, input bit gaps, output bit ok);
        if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge cpu_clk);
            #1;
        end
        cur_addr = addr;
        cur_trn  = trn;
        in_data  = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge cpu_clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0 at offset %0d, expected 1", addr);
        end
        @(posedge cpu_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_image(input bit gaps, input int stop_after);
        bit ok;
        for (int off = 0; off < IMG_LEN; off++) begin
            send(img_byte(off), off, 1'b0, gaps, ok);
            if (!ok || off == stop_after) return;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge cpu_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge cpu_clk);
        #1;
        rst = 1'b0;
        wr_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     int'(busy), 0);
        check({tag, "_done"},     int'(done), 0);
        check({tag, "_err"},      int'(err), 0);
        check({tag, "_err_code"}, int'(err_code), 0);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_wr_en"},    int'(wr_en), 0);
        check({tag, "_wr_addr"},  int'(wr_addr), 0);
        check({tag, "_wr_data"},  int'(wr_data), 0);
        check({tag, "_prg"},      int'(prg_banks), 0);
        check({tag, "_chr"},      int'(chr_banks), 0);
        check({tag, "_mirror"},   int'(mirror_v), 0);
    endtask

    initial begin
        logic [63:0] h;
        logic [7:0]  b;
        bit          ok;

        vecs[0]  = '{"magic_b0",   64'h4F45531A_01010000, 1, 0};
        vecs[1]  = '{"magic_b2",   64'h4E45541A_01010000, 1, 2};
        vecs[2]  = '{"magic_b3",   64'h4E45531B_01010000, 1, 3};
        vecs[3]  = '{"prg2",       64'h4E45531A_02010000, 2, 7};
        vecs[4]  = '{"prg0",       64'h4E45531A_00010000, 2, 7};
        vecs[5]  = '{"chr0",       64'h4E45531A_01000000, 2, 7};
        vecs[6]  = '{"chr2",       64'h4E45531A_01020000, 2, 7};
        vecs[7]  = '{"mapper1",    64'h4E45531A_01011000, 2, 7};
        vecs[8]  = '{"mapper16",   64'h4E45531A_01010010, 2, 7};
`ifdef INES_TRAINER_SKIP_EN
        vecs[9]  = '{"trainer",    64'h4E45531A_01010400, 0, 7};
`else
        vecs[9]  = '{"trainer",    64'h4E45531A_01010400, 2, 7};
`endif
        vecs[10] = '{"mirror_ok",  64'h4E45531A_01010100, 0, 7};

        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        @(posedge cpu_clk);
        #1 rst = 1'b0;

        // start and in_valid together in IDLE: byte must not be taken.
        in_valid = 1'b1;
        in_data  = 8'h4E;
        cur_addr = 0;
        start    = 1'b1;
        @(posedge cpu_clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge cpu_clk);
        #1 check("idle_start_no_write", wr_cnt, 0);
        check("idle_start_busy", int'(busy), 1);
        @(posedge cpu_clk);
        #1;

        for (int r = 0; r < 11; r++) begin
            exp_last = -1;
            do_reset();
            pulse_start();
            h = vecs[r].hdr;
            for (int k = 0; k <= vecs[r].last; k++) begin
                b = h[63 - 8*k -: 8];
                send(b, k, 1'b0, 1'b0, ok);
            end
            @(negedge cpu_clk);
            @(negedge cpu_clk);
            #1;
            check({vecs[r].name, "_err"},      int'(err), int'(vecs[r].code != 0));
            check({vecs[r].name, "_err_code"}, int'(err_code), vecs[r].code);
            check({vecs[r].name, "_in_ready"}, int'(in_ready), int'(vecs[r].code == 0));
            check({vecs[r].name, "_done"},     int'(done), 0);
            check({vecs[r].name, "_writes"},   wr_cnt, vecs[r].last + 1);
            if (vecs[r].last >= 4) check({vecs[r].name, "_prg"}, int'(prg_banks), int'(h[31:24]));
            if (vecs[r].last >= 6) check({vecs[r].name, "_mirror"}, int'(mirror_v), int'(h[8]));
            @(posedge cpu_clk);
            #1;
            if (vecs[r].code != 0) begin
                pulse_start();
                check({vecs[r].name, "_restart_err"},  int'(err), 0);
                check({vecs[r].name, "_restart_code"}, int'(err_code), 0);
                check({vecs[r].name, "_restart_busy"}, int'(busy), 1);
            end
        end

        // Full image, continuous stream.
        do_reset();
        exp_last = IMG_LEN - 1;
        pulse_start();
        load_image(1'b0, -1);
        @(negedge cpu_clk);
        #1;
        check("full_done",      int'(done), 1);
        check("full_busy",      int'(busy), 0);
        check("full_in_ready",  int'(in_ready), 0);
        check("full_err",       int'(err), 0);
        check("full_prg",       int'(prg_banks), 1);
        check("full_chr",       int'(chr_banks), 1);
        check("full_writes",    wr_cnt, IMG_LEN);
        check("full_last_addr", last_addr, 16'h600F);
        check("full_last_data", int'(last_data), int'(img_byte(IMG_LEN - 1)));
        check("full_wr_bad",    wr_bad, 0);
        repeat (3) @(negedge cpu_clk);
        #1 check("full_done_hold", int'(done), 1);
        @(posedge cpu_clk);
        #1;

        // Restart from DONE, then reset in the middle of PRG.
        exp_last = -1;
        wr_cnt   = 0;
        pulse_start();
        check("restart_done", int'(done), 0);
        check("restart_busy", int'(busy), 1);
        load_image(1'b0, 16 + 5000);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        @(posedge cpu_clk);
        #1 rst = 1'b0;
        wr_cnt = 0;

        // Full image with random valid gaps after the abandoned load.
        exp_last = IMG_LEN - 1;
        pulse_start();
        load_image(1'b1, -1);
        @(negedge cpu_clk);
        #1;
        check("gap_done",      int'(done), 1);
        check("gap_writes",    wr_cnt, IMG_LEN);
        check("gap_last_addr", last_addr, 16'h600F);
        check("gap_wr_bad",    wr_bad, 0);
        @(posedge cpu_clk);
        #1;

`ifdef INES_TRAINER_SKIP_EN
        exp_last = -1;
        do_reset();
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            b = (k == 6) ? 8'h04 : img_byte(k);
            send(b, k, 1'b0, 1'b0, ok);
        end
        for (int k = 0; k < 512; k++) begin
            b = 8'(k);
            send(b, 16, 1'b1, 1'b0, ok);
        end
        @(negedge cpu_clk);
        #1;
        check("trn_writes_hdr", wr_cnt, 16);
        check("trn_busy",       int'(busy), 1);
        @(posedge cpu_clk);
        #1;
        send(8'hA5, 16, 1'b0, 1'b0, ok);
        @(negedge cpu_clk);
        #1;
        check("trn_prg_addr",   last_addr, 16);
        check("trn_prg_data",   int'(last_data), 8'hA5);
        check("trn_writes",     wr_cnt, 17);
        @(posedge cpu_clk);
        #1;
`endif

        check("final_wr_bad", wr_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
